// File: rtl/pfu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : pfu_pkg                                                    |
// | Shared definitions for the program fetch unit: FSM state encoding,   |
// | default instruction / IP widths and the default fault word.          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package pfu_pkg;

  localparam int PFU_INSTR_W = 26;
  localparam int PFU_IP_W    = 16;

  localparam logic [PFU_INSTR_W-1:0] PFU_NOP_WORD = '0;

  // Controller states
  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pfu_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pfu_out_fifo                                               |
// | Two-entry in-order output buffer with valid/ready pop side.          |
// | Slot 0 is always the head; when the buffer empties the head slot     |
// | keeps the last popped word so the outputs hold their last value.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
// | Ports                                                                |
// |  clock      in   clock, rising edge                                  |
// |  reset_n    in   asynchronous active-low reset                       |
// |  push       in   write push_data (caller guarantees room)            |
// |  push_data  in   entry to append                                     |
// |  pop_ready  in   consumer takes the head when valid                  |
// |  valid      out  head holds a live entry                             |
// |  head       out  head entry (or last popped entry when empty)        |
// |  count      out  current occupancy, 0..2                             |
// +----------------------------------------------------------------------+
module pfu_out_fifo #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         w_pop;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    w_pop   = (count_q != 2'd0) && pop_ready;
    case ({push, w_pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = push_data;
        else                 slot1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // With a single entry the head slot is left alone so it keeps
        // presenting the word just consumed.
        if (count_q == 2'd2) slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end else begin
          slot0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot0_q <= RESET_VAL;
      slot1_q <= RESET_VAL;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign valid = (count_q != 2'd0);
  assign head  = slot0_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/program_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : program_fetch_unit                                         |
// | Instruction store plus fetch front-end. Loaded word-by-word while in |
// | LOAD, serves IP-addressed fetches in RUN through a one-deep read     |
// | stage and a two-entry output buffer, flags misaligned/out-of-range   |
// | IPs with a NOP word.                                                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
// | Ports                                                                |
// |  clock, reset_n           clock / async active-low reset             |
// |  load_en/addr/data  in    store write port (word index), LOAD only   |
// |  run_start, halt    in    LOAD->RUN, RUN->DRAIN                      |
// |  running            out   state is RUN                               |
// |  fetch_req/ip       in    fetch request, accepted with fetch_ready   |
// |  fetch_ready        out                                              |
// |  instr_valid, instr, instr_ip, fetch_fault  out  buffer head         |
// |  instr_ready        in    consumer pops head                         |
// +----------------------------------------------------------------------+
module program_fetch_unit
  import pfu_pkg::*;
#(
  parameter int                 INSTR_W   = PFU_INSTR_W,
  parameter int                 IP_W      = PFU_IP_W,
  parameter int                 DEPTH     = 64,
  parameter int                 IP_STRIDE = 3,
  parameter logic [INSTR_W-1:0] NOP_WORD  = PFU_NOP_WORD
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load_en,
  input  logic [IP_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               run_start,
  input  logic               halt,
  output logic               running,
  input  logic               fetch_req,
  input  logic [IP_W-1:0]    fetch_ip,
  output logic               fetch_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [IP_W-1:0]    instr_ip,
  output logic               fetch_fault,
  input  logic               instr_ready
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = INSTR_W + IP_W + 1;

  logic [1:0]         state_q, state_d;
  logic               inflight_q, inflight_d;
  logic [INSTR_W-1:0] rd_data_q, rd_data_d;
  logic [IP_W-1:0]    rd_ip_q, rd_ip_d;
  logic               rd_fault_q, rd_fault_d;

  logic [INSTR_W-1:0] store_q [DEPTH];

  logic [IP_W-1:0]    w_idx;
  logic [IP_W-1:0]    w_rem;
  logic               w_fault;
  logic               w_accept;
  logic               w_pop;
  logic               w_load_we;
  logic [2:0]         w_pending;
  logic [1:0]         w_occ;
  logic [ENT_W-1:0]   w_head;

  always_comb begin
    w_idx   = fetch_ip / IP_W'(IP_STRIDE);
    w_rem   = fetch_ip % IP_W'(IP_STRIDE);
    w_fault = (w_rem != '0) || (w_idx >= IP_W'(DEPTH));

    w_pop = instr_valid && instr_ready;
    // Occupancy is taken net of the head leaving this cycle so that a
    // steady stream with instr_ready high sustains one fetch per cycle.
    w_pending   = 3'(w_occ) + 3'(inflight_q) - 3'(w_pop);
    fetch_ready = (state_q == ST_RUN) && !halt && (w_pending < 3'd2);
    w_accept    = fetch_req && fetch_ready;

    w_load_we = (state_q == ST_LOAD) && load_en && (load_addr < IP_W'(DEPTH));

    // Synchronous store read captured on the accepting edge; the result
    // is pushed into the buffer on the following edge.
    inflight_d = w_accept;
    rd_data_d  = rd_data_q;
    rd_ip_d    = rd_ip_q;
    rd_fault_d = rd_fault_q;
    if (w_accept) begin
      rd_data_d  = w_fault ? NOP_WORD : store_q[w_idx[AW-1:0]];
      rd_ip_d    = fetch_ip;
      rd_fault_d = w_fault;
    end

    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (run_start) state_d = ST_RUN;
      ST_RUN:   if (halt) state_d = ST_DRAIN;
      ST_DRAIN: if (!inflight_q && (w_occ == 2'd0)) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_LOAD;
      inflight_q <= 1'b0;
      rd_data_q  <= NOP_WORD;
      rd_ip_q    <= '0;
      rd_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      rd_data_q  <= rd_data_d;
      rd_ip_q    <= rd_ip_d;
      rd_fault_q <= rd_fault_d;
    end
  end

  // Program contents survive reset.
  always_ff @(posedge clock) begin
    if (w_load_we) store_q[load_addr[AW-1:0]] <= load_data;
  end

  pfu_out_fifo #(
    .W         (ENT_W),
    .RESET_VAL ({NOP_WORD, {IP_W{1'b0}}, 1'b0})
  ) u_out_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data ({rd_data_q, rd_ip_q, rd_fault_q}),
    .pop_ready (instr_ready),
    .valid     (instr_valid),
    .head      (w_head),
    .count     (w_occ)
  );

  assign instr       = w_head[ENT_W-1 -: INSTR_W];
  assign instr_ip    = w_head[IP_W:1];
  assign fetch_fault = w_head[0];
  assign running     = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_program_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_program_fetch_unit                                      |
// | Directed self-checking bench for program_fetch_unit.                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_program_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic        load_en;
  logic [15:0] load_addr;
  logic [25:0] load_data;
  logic        run_start;
  logic        halt;
  logic        running;
  logic        fetch_req;
  logic [15:0] fetch_ip;
  logic        fetch_ready;
  logic        instr_valid;
  logic [25:0] instr;
  logic [15:0] instr_ip;
  logic        fetch_fault;
  logic        instr_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [25:0] prog [7] = '{26'h0400000, 26'h0428001, 26'h0400002, 26'h0600050,
                            26'h0604012, 26'h0E01013, 26'h14C0018};

  program_fetch_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .run_start   (run_start),
    .halt        (halt),
    .running     (running),
    .fetch_req   (fetch_req),
    .fetch_ip    (fetch_ip),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ip    (instr_ip),
    .fetch_fault (fetch_fault),
    .instr_ready (instr_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0h want 0", instr_valid); end
    n_cmp++; if (instr !== 26'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_cmp++; if (instr_ip !== 16'h0) begin n_bad++; $display("FAIL rst_ip: got %h want 0", instr_ip); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %0h want 0", fetch_fault); end
    n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0h want 0", fetch_ready); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL rst_running: got %0h want 0", running); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 7; i++) begin
      load_en = 1'b1; load_addr = 16'(i); load_data = prog[i];
      cyc();
    end
    // Out-of-range load must not alias onto word 0
    load_addr = 16'd64; load_data = 26'h3FFFFFF;
    cyc();
    load_en = 1'b0;
    run_start = 1'b1;
    cyc();
    run_start = 1'b0;
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL run_entry: got %0h want 1", running); end
    instr_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      fetch_req = (k < 7);
      fetch_ip  = 16'(3 * k);
      #1;
      if (k < 7) begin
        n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready[%0d]: got %0h want 1", k, fetch_ready); end
      end
      if (k < 2) begin
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid[%0d]: got %0h want 0", k, instr_valid); end
      end else begin
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %0h want 1", k, instr_valid); end
        n_cmp++; if (instr !== prog[k-2]) begin n_bad++; $display("FAIL stream_instr[%0d]: got %h want %h", k, instr, prog[k-2]); end
        n_cmp++; if (instr_ip !== 16'(3 * (k - 2))) begin n_bad++; $display("FAIL stream_ip[%0d]: got %0d want %0d", k, instr_ip, 3 * (k - 2)); end
        n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL stream_fault[%0d]: got %0h want 0", k, fetch_fault); end
      end
      cyc();
    end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL stream_empty: got %0h want 0", instr_valid); end
    n_cmp++; if (instr !== prog[6]) begin n_bad++; $display("FAIL stream_hold_last: got %h want %h", instr, prog[6]); end
  endtask

  task automatic test_fault();
    fetch_req = 1'b1; fetch_ip = 16'd4;
    cyc();
    fetch_req = 1'b0;
    cyc();
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL mis_valid: got %0h want 1", instr_valid); end
    n_cmp++; if (instr !== 26'h0) begin n_bad++; $display("FAIL mis_instr: got %h want 0", instr); end
    n_cmp++; if (fetch_fault !== 1'b1) begin n_bad++; $display("FAIL mis_fault: got %0h want 1", fetch_fault); end
    n_cmp++; if (instr_ip !== 16'd4) begin n_bad++; $display("FAIL mis_ip: got %0d want 4", instr_ip); end
    fetch_req = 1'b1; fetch_ip = 16'd192;
    cyc();
    fetch_req = 1'b0;
    cyc();
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL oor_valid: got %0h want 1", instr_valid); end
    n_cmp++; if (instr !== 26'h0) begin n_bad++; $display("FAIL oor_instr: got %h want 0", instr); end
    n_cmp++; if (fetch_fault !== 1'b1) begin n_bad++; $display("FAIL oor_fault: got %0h want 1", fetch_fault); end
    n_cmp++; if (instr_ip !== 16'd192) begin n_bad++; $display("FAIL oor_ip: got %0d want 192", instr_ip); end
    cyc();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL fault_empty: got %0h want 0", instr_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] ips [3] = '{16'd0, 16'd3, 16'd6};
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fetch_req = 1'b1; fetch_ip = ips[k];
      #1;
      n_cmp++; if (fetch_ready !== (k < 2)) begin n_bad++; $display("FAIL bp_ready[%0d]: got %0h want %0h", k, fetch_ready, (k < 2)); end
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready[%0d]: got %0h want 0", k, fetch_ready); end
      n_cmp++; if (instr !== prog[0] || instr_ip !== 16'd0 || instr_valid !== 1'b1) begin
        n_bad++; $display("FAIL bp_stable[%0d]: got %h/%0d/%0h want %h/0/1", k, instr, instr_ip, instr_valid, prog[0]);
      end
      cyc();
    end
    fetch_req = 1'b0;
    instr_ready = 1'b1;
    #1;
    n_cmp++; if (instr !== prog[0]) begin n_bad++; $display("FAIL bp_rel0: got %h want %h", instr, prog[0]); end
    cyc();
    n_cmp++; if (instr !== prog[1] || instr_ip !== 16'd3 || instr_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_rel1: got %h/%0d/%0h want %h/3/1", instr, instr_ip, instr_valid, prog[1]);
    end
    cyc();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %0h want 0", instr_valid); end
  endtask

  task automatic test_halt_drain();
    instr_ready = 1'b0;
    load_en = 1'b1; load_addr = 16'd0; load_data = 26'h3FFFFFF;
    fetch_req = 1'b1; fetch_ip = 16'd0;
    cyc();
    fetch_ip = 16'd3;
    cyc();
    load_en = 1'b0;
    halt = 1'b1; fetch_ip = 16'd6;
    #1;
    n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL halt_ready: got %0h want 0", fetch_ready); end
    cyc();
    halt = 1'b0; fetch_req = 1'b0;
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL drain_running: got %0h want 0", running); end
    // run_start in DRAIN is ignored
    run_start = 1'b1;
    cyc();
    run_start = 1'b0;
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL drain_ignore_start: got %0h want 0", running); end
    instr_ready = 1'b1;
    #1;
    n_cmp++; if (instr !== prog[0] || instr_valid !== 1'b1) begin n_bad++; $display("FAIL drain_pop0: got %h/%0h want %h/1", instr, instr_valid, prog[0]); end
    cyc();
    n_cmp++; if (instr !== prog[1] || instr_valid !== 1'b1) begin n_bad++; $display("FAIL drain_pop1: got %h/%0h want %h/1", instr, instr_valid, prog[1]); end
    cyc();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %0h want 0", instr_valid); end
    cyc();
    run_start = 1'b1;
    cyc();
    run_start = 1'b0;
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL drain_to_load: got %0h want 1", running); end
    fetch_req = 1'b1; fetch_ip = 16'd0;
    cyc();
    fetch_req = 1'b0;
    cyc();
    n_cmp++; if (instr !== prog[0]) begin n_bad++; $display("FAIL run_load_ignored: got %h want %h", instr, prog[0]); end
    cyc();
  endtask

  task automatic test_load_and_start();
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    cyc();
    load_en = 1'b1; load_addr = 16'd1; load_data = 26'h0000ABC; run_start = 1'b1;
    cyc();
    load_en = 1'b0; run_start = 1'b0;
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL ls_running: got %0h want 1", running); end
    fetch_req = 1'b1; fetch_ip = 16'd3;
    cyc();
    fetch_req = 1'b0;
    cyc();
    n_cmp++; if (instr !== 26'h0000ABC || instr_ip !== 16'd3) begin n_bad++; $display("FAIL ls_instr: got %h/%0d want 0000abc/3", instr, instr_ip); end
    cyc();
  endtask

  task automatic test_reset_midrun();
    instr_ready = 1'b0;
    fetch_req = 1'b1; fetch_ip = 16'd0;
    cyc();
    fetch_ip = 16'd6;
    cyc();
    fetch_req = 1'b0;
    cyc();
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL mr_pre_valid: got %0h want 1", instr_valid); end
    reset_n = 1'b0;
    cyc();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL mr_valid: got %0h want 0", instr_valid); end
    n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL mr_ready: got %0h want 0", fetch_ready); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL mr_running: got %0h want 0", running); end
    n_cmp++; if (instr !== 26'h0) begin n_bad++; $display("FAIL mr_instr: got %h want 0", instr); end
    reset_n = 1'b1;
    instr_ready = 1'b1;
    cyc();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL mr_post_valid: got %0h want 0", instr_valid); end
    run_start = 1'b1;
    cyc();
    run_start = 1'b0;
    fetch_req = 1'b1; fetch_ip = 16'd6;
    cyc();
    fetch_req = 1'b0;
    cyc();
    n_cmp++; if (instr !== prog[2] || instr_valid !== 1'b1) begin n_bad++; $display("FAIL mr_store_kept: got %h/%0h want %h/1", instr, instr_valid, prog[2]); end
  endtask

  initial begin
    reset_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    run_start = 1'b0; halt = 1'b0; fetch_req = 1'b0; fetch_ip = '0; instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_fault();
    test_backpressure();
    test_halt_drain();
    test_load_and_start();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
